// File: rtl/wishbone_pkg.sv
// Shared Wishbone B4 constants: cycle type, burst type
// and the slave responder state encoding.
package wishbone_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR = 2'b00;
   localparam logic [1:0] BTE_WRAP4  = 2'b01;
   localparam logic [1:0] BTE_WRAP8  = 2'b10;
   localparam logic [1:0] BTE_WRAP16 = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } wb_state_e;

endpackage

// File: rtl/wishbone_burst_addr.sv
// Next word index of an incrementing burst for a given BTE,
// plus whether that index still lies inside the memory.
module wishbone_burst_addr
   import wishbone_pkg::*;
#(
   parameter int IDX_W     = 4,
   parameter int MEM_DEPTH = 16
) (
   input  logic [IDX_W-1:0] idx_i,
   input  logic [1:0]       bte_i,
   output logic [IDX_W-1:0] nxt_o,
   output logic             inr_o
);

   logic [IDX_W-1:0] inc;
   logic [IDX_W-1:0] mask;

   always_comb begin
      inc  = idx_i + IDX_W'(1);
      mask = IDX_W'(MEM_DEPTH - 1);
      unique case (bte_i)
         BTE_LINEAR: mask = IDX_W'(MEM_DEPTH - 1);
         BTE_WRAP4:  mask = IDX_W'(3);
         BTE_WRAP8:  mask = IDX_W'(7);
         BTE_WRAP16: mask = IDX_W'(15);
         default:    mask = IDX_W'(MEM_DEPTH - 1);
      endcase
      // Upper bits stay put, the bits inside the block wrap.
      nxt_o = (idx_i & ~mask) | (inc & mask);
      inr_o = {1'b0, nxt_o} < (IDX_W + 1)'(MEM_DEPTH);
   end

endmodule

// File: rtl/wishbone_mem_slave.sv
// Wishbone B4 memory slave: byte selects, wait states,
// error on out-of-range access, CTI/BTE incrementing bursts.
module wishbone_mem_slave
   import wishbone_pkg::*;
#(
   parameter int WB_ADDR_W   = 32,
   parameter int WB_DATA_W   = 32,
   parameter int WB_TGD_W    = 8,
   parameter int WB_TGC_W    = 4,
   parameter int WB_TGA_W    = 2,
   parameter int MEM_DEPTH   = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic                   CLK_I,
   input  logic                   RST_I,
   input  logic [WB_ADDR_W-1:0]   ADR_I,
   input  logic [WB_DATA_W-1:0]   DAT_I,
   output logic [WB_DATA_W-1:0]   DAT_O,
   input  logic [WB_DATA_W/8-1:0] SEL_I,
   input  logic                   WE_I,
   input  logic                   STB_I,
   input  logic                   CYC_I,
   input  logic                   LOCK_I,
   input  logic [WB_TGD_W-1:0]    TGD_I,
   input  logic [WB_TGA_W-1:0]    TGA_I,
   input  logic [WB_TGC_W-1:0]    TGC_I,
   input  logic [2:0]             CTI_I,
   input  logic [1:0]             BTE_I,
   output logic                   ACK_O,
   output logic                   ERR_O,
   output logic                   RTY_O
);

   localparam int NB    = WB_DATA_W / 8;
   localparam int BW    = $clog2(NB);
   localparam int AW    = $clog2(MEM_DEPTH);
   localparam int IDX_W = (AW > 4) ? AW : 4;

   wb_state_e state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 inr_q, inr_d;
   logic [WB_DATA_W-1:0] dat_q, dat_d;
   logic [WB_DATA_W-1:0] mem_q [MEM_DEPTH];

   logic [IDX_W-1:0] adr_idx;
   logic             adr_inr;
   logic [IDX_W-1:0] nxt_idx;
   logic             nxt_inr;
   logic             beat;
   logic             resp;
   logic             wr_en;
   logic             unused_ok;

   assign adr_idx = ADR_I[BW +: IDX_W];
   assign adr_inr = (ADR_I >> (BW + AW)) == '0;
   assign beat    = CYC_I & STB_I;

   wishbone_burst_addr #(
      .IDX_W     (IDX_W),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_burst_addr (
      .idx_i (idx_q),
      .bte_i (BTE_I),
      .nxt_o (nxt_idx),
      .inr_o (nxt_inr)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      inr_d   = inr_q;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (beat) begin
               idx_d = adr_idx;
               inr_d = adr_inr;
               if (WAIT_STATES > 0) begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (!beat) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            // STB low with CYC high is a master wait: hold.
            if (!CYC_I) begin
               state_d = IDLE;
            end else if (STB_I) begin
               wr_en = inr_q & WE_I;
               if (inr_q && CTI_I == CTI_INCR) begin
                  idx_d = nxt_idx;
                  inr_d = nxt_inr;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      dat_d = '0;
      if (state_d == RESP && inr_d) begin
         dat_d = mem_q[idx_d[AW-1:0]];
      end
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         inr_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         inr_q   <= inr_d;
         dat_q   <= dat_d;
      end
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (SEL_I[b]) begin
               mem_q[idx_q[AW-1:0]][8*b +: 8] <= DAT_I[8*b +: 8];
            end
         end
      end
   end

   assign resp  = (state_q == RESP) & beat;
   assign ACK_O = resp & inr_q;
   assign ERR_O = resp & ~inr_q;
   assign RTY_O = 1'b0;
   assign DAT_O = ACK_O ? dat_q : '0;

   assign unused_ok = ^{LOCK_I, TGD_I, TGA_I, TGC_I, ADR_I};

endmodule

// File: doc/wishbone_mem_slave.md
Name: wishbone_mem_slave

Overview:
- Parametrised Wishbone B4 slave with a byte-addressed register/memory array, full read and write support, byte selects, programmable wait states, an error response for out-of-range accesses, and registered-feedback incrementing bursts (CTI/BTE).
- Next-generation replacement for the write-ack-only bench slave. It sits behind the interconnect as the DUT-side responder for master-agent verification and example systems.

Parameters:
- WB_ADDR_W, 32: address width (byte address).
- WB_DATA_W, 32: data width; legal values 8, 16, 32, 64.
- WB_TGD_W, 8: data tag width; accepted, ignored.
- WB_TGC_W, 4: cycle tag width; accepted, ignored.
- WB_TGA_W, 2: address tag width; accepted, ignored.
- MEM_DEPTH, 16: number of WB_DATA_W words; power of two, at least 4.
- WAIT_STATES, 0: idle cycles inserted before the first response of each access; range 0..15.

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  asynchronous reset, active low
- ADR_I  in  WB_ADDR_W  byte address
- DAT_I  in  WB_DATA_W  write data
- DAT_O  out  WB_DATA_W  read data, registered
- SEL_I  in  WB_DATA_W/8  byte enables
- WE_I  in  1  1 = write
- STB_I  in  1  strobe
- CYC_I  in  1  cycle valid
- LOCK_I  in  1  ignored
- TGD_I, TGA_I, TGC_I  in  per parameters  ignored
- CTI_I  in  3  cycle type identifier
- BTE_I  in  2  burst type extension
- ACK_O  out  1  normal termination
- ERR_O  out  1  error termination
- RTY_O  out  1  tied to 0

Behaviour:
- Reset (RST_I low, asynchronous): state = IDLE; ACK_O = 0, ERR_O = 0, RTY_O = 0, DAT_O = 0; wait counter = 0; every memory word cleared to 0.
- Address decode:
  - BW = log2(WB_DATA_W/8); word index = ADR_I >> BW.
  - Access is in range iff the index < MEM_DEPTH, with all upper address bits compared.
  - Low BW address bits are ignored.
- State machine IDLE / WAIT / RESP:
  - IDLE: if CYC_I & STB_I, capture index, WE, in-range flag and SEL. Go to WAIT with counter = WAIT_STATES-1 if WAIT_STATES > 0, else go to RESP.
  - WAIT: decrement the counter; go to RESP when it is 0. If CYC_I or STB_I drops, go to IDLE with no response and no write.
  - RESP: exactly one of ACK_O or ERR_O is high.
    - ACK_O = in range; ERR_O = out of range.
    - For reads, DAT_O holds mem[index] during this cycle.
    - For in-range writes, bytes with SEL_I = 1 are written on the edge that ends RESP. Bytes with SEL_I = 0 are unchanged.
- Latency: request first seen in cycle T → response in cycle T+1+WAIT_STATES.
- Classic cycle (CTI_I = 000 or 111 in RESP): RESP → IDLE. Minimum one dead cycle between back-to-back classic accesses.
- Burst (CTI_I = 010 sampled in RESP with CYC_I & STB_I, in range):
  - Stay in RESP and acknowledge every cycle, with no wait states after the first beat.
  - The next index is computed internally from BTE_I:
    - 00: linear, index+1 mod MEM_DEPTH.
    - 01: wrap within an aligned 4-beat block.
    - 10: wrap within an aligned 8-beat block.
    - 11: wrap within an aligned 16-beat block.
  - Read data for the next beat is fetched from the computed index.
  - A beat with CTI_I = 111 is the last beat; go to IDLE after it.
  - STB_I low in RESP with CYC_I high: deassert ACK_O and hold the index (master wait). Resume when STB_I returns.
  - CYC_I low at any point: go to IDLE.
- Errors inside a burst:
  - If a computed index falls outside MEM_DEPTH (only possible when wrap size exceeds MEM_DEPTH), assert ERR_O for that beat and go to IDLE.
  - An out-of-range first beat always terminates with ERR_O and goes to IDLE, regardless of CTI_I.
- CTI_I = 001 (constant address) or a reserved value: treat as classic.
- Simultaneous events: reset overrides everything. CYC_I dropping in the same cycle as RESP cancels the pending write.
- DAT_O returns to 0 in every cycle without ACK_O.

Decomposition:
- Shared package wishbone_pkg:
  - CTI constants: CLASSIC = 000, CONST = 001, INCR = 010, EOB = 111.
  - BTE constants: LINEAR = 00, WRAP4 = 01, WRAP8 = 10, WRAP16 = 11.
  - Slave state enum: IDLE, WAIT, RESP.
- Sub-module wishbone_burst_addr: purely combinational next-index calculation from index, BTE and MEM_DEPTH. Reused by the master agent model.

Test Plan:
- Write then read, WAIT_STATES = 0: write 0xDEADBEEF to address 0x08 with SEL = 1111, then read 0x08 → ACK one cycle after STB each time; DAT_O = 0xDEADBEEF.
- Byte select: write 0x11223344 with SEL = 0101 to cleared address 0x04, then read → DAT_O = 0x00220044.
- Wait states: WAIT_STATES = 3, read at cycle T → ACK_O high only at T+4 for exactly one cycle; abort by dropping CYC_I at T+2 → no ACK, memory unchanged.
- Out of range: MEM_DEPTH = 16, write to 0x40 or 0x80000000 → ERR_O for one cycle, ACK_O = 0; a later read of 0x00 returns 0.
- Wrap4 read burst: memory preloaded with mem[i] = i, start at 0x08 with CTI = 010, BTE = 01, four beats (last with CTI = 111) → ACK on four consecutive cycles; data 2, 3, 0, 1; then IDLE.
- Reset mid-burst: assert RST_I low during beat 2 of a linear burst → ACK_O = 0 and DAT_O = 0 immediately (asynchronous); memory reads 0 after release.
